// File: rtl/aligner_axis_out.sv
// Aligner output stage: beat FIFO ending in the AXI-Stream output register, early in_ready
// backpressure, and a per-packet byte counter reported on each tlast handshake.
module aligner_axis_out #(
  parameter int DATA_WIDTH   = 256,
  parameter int DEPTH        = 16,
  parameter int AFULL_MARGIN = 4,
  parameter int CNT_WIDTH    = 32
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    in_valid,
  input  logic                    in_tlast,
  input  logic [DATA_WIDTH-1:0]   in_data,
  input  logic [DATA_WIDTH/8-1:0] in_tkeep,
  output logic                    in_ready,
  output logic [DATA_WIDTH-1:0]   m_axis_tdata,
  output logic [DATA_WIDTH/8-1:0] m_axis_tkeep,
  output logic                    m_axis_tlast,
  output logic                    m_axis_tvalid,
  input  logic                    m_axis_tready,
  output logic [CNT_WIDTH-1:0]    pkt_bytes,
  output logic                    pkt_done,
  output logic                    overflow
);

  localparam int KW    = DATA_WIDTH / 8;
  localparam int AW    = $clog2(DEPTH);
  localparam int OCC_W = AW + 1;
  localparam int WW    = DATA_WIDTH + KW + 1;
  localparam logic [OCC_W-1:0] OCC_FULL   = OCC_W'(DEPTH);
  localparam logic [OCC_W-1:0] OCC_AFULL  = OCC_W'(DEPTH - AFULL_MARGIN);

  typedef enum logic {IDLE, BODY} state_t;

  // Storage behind the output register; combinational read feeds the output register directly.
  logic [WW-1:0] mem [DEPTH];

  logic [AW-1:0]         wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [OCC_W-1:0]      occ_q, occ_d;
  logic                  tvalid_q, tvalid_d;
  logic [DATA_WIDTH-1:0] tdata_q, tdata_d;
  logic [KW-1:0]         tkeep_q, tkeep_d;
  logic                  tlast_q, tlast_d;
  logic                  in_ready_q, in_ready_d;
  logic                  overflow_q, overflow_d;

  logic pop, accept, load_out, mem_empty, mem_wr, mem_rd;
  logic [WW-1:0] mem_rdata;

  state_t               state_q;
  logic [CNT_WIDTH-1:0] acc_q, pkt_bytes_q, beat_bytes;
  logic                 pkt_done_q;

  function automatic logic [CNT_WIDTH-1:0] popcount(input logic [KW-1:0] k);
    logic [CNT_WIDTH-1:0] n;
    n = '0;
    for (int i = 0; i < KW; i++) n = n + CNT_WIDTH'(k[i]);
    return n;
  endfunction

  always_comb begin
    pop       = tvalid_q & m_axis_tready;
    accept    = in_valid & ((occ_q < OCC_FULL) | pop);
    // Everything held that is not in the output register lives in mem.
    mem_empty = (occ_q == {{AW{1'b0}}, tvalid_q});
    load_out  = ~tvalid_q | pop;
    mem_rd    = load_out & ~mem_empty;
    mem_wr    = accept & ~(load_out & mem_empty);
    mem_rdata = mem[rd_ptr_q];

    tvalid_d  = tvalid_q;
    tdata_d   = tdata_q;
    tkeep_d   = tkeep_q;
    tlast_d   = tlast_q;
    rd_ptr_d  = rd_ptr_q;
    wr_ptr_d  = wr_ptr_q;

    if (mem_rd) begin
      {tlast_d, tkeep_d, tdata_d} = mem_rdata;
      tvalid_d = 1'b1;
      rd_ptr_d = rd_ptr_q + AW'(1);
    end else if (load_out) begin
      tvalid_d = accept;
      if (accept) begin
        tdata_d = in_data;
        tkeep_d = in_tkeep;
        tlast_d = in_tlast;
      end
    end

    if (mem_wr) wr_ptr_d = wr_ptr_q + AW'(1);

    occ_d      = occ_q + OCC_W'(accept) - OCC_W'(pop);
    in_ready_d = (occ_d <= OCC_AFULL);
    overflow_d = overflow_q | (in_valid & ~accept);
    beat_bytes = popcount(tkeep_q);
  end

  always_ff @(posedge clk) begin
    if (mem_wr) mem[wr_ptr_q] <= {in_tlast, in_tkeep, in_data};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      occ_q      <= '0;
      tvalid_q   <= 1'b0;
      tdata_q    <= '0;
      tkeep_q    <= '0;
      tlast_q    <= 1'b0;
      in_ready_q <= 1'b1;
      overflow_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      occ_q      <= occ_d;
      tvalid_q   <= tvalid_d;
      tdata_q    <= tdata_d;
      tkeep_q    <= tkeep_d;
      tlast_q    <= tlast_d;
      in_ready_q <= in_ready_d;
      overflow_q <= overflow_d;
    end
  end

  // Packet byte counter advances only on output handshakes.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      acc_q       <= '0;
      pkt_bytes_q <= '0;
      pkt_done_q  <= 1'b0;
    end else begin
      pkt_done_q <= 1'b0;
      if (pop) begin
        if (tlast_q) begin
          pkt_bytes_q <= ((state_q == BODY) ? acc_q : '0) + beat_bytes;
          pkt_done_q  <= 1'b1;
          state_q     <= IDLE;
        end else begin
          acc_q   <= ((state_q == IDLE) ? '0 : acc_q) + beat_bytes;
          state_q <= BODY;
        end
      end
    end
  end

  assign in_ready      = in_ready_q;
  assign m_axis_tdata  = tdata_q;
  assign m_axis_tkeep  = tkeep_q;
  assign m_axis_tlast  = tlast_q;
  assign m_axis_tvalid = tvalid_q;
  assign pkt_bytes     = pkt_bytes_q;
  assign pkt_done      = pkt_done_q;
  assign overflow      = overflow_q;

endmodule
